// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the processor memory bus.
//
// Accepts BUS_LOAD / BUS_STORE commands, grants a nonzero tag in the same cycle,
// and returns tagged load data LATENCY cycles after acceptance. The backing
// store is a synthesizable array of 64-bit doublewords that survives reset.
//
// Ports:
//   clock              system clock
//   reset              asynchronous active-low reset
//   proc2mem_command   BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2, 3=illegal
//   proc2mem_addr      byte address
//   proc2mem_data      store data, right-aligned for sub-doubleword sizes
//   proc2mem_size      BYTE=0, HALF=1, WORD=2, DOUBLE=3
//   mem_refuse         forces rejection of this cycle's command
//   mem2proc_response  granted tag this cycle, 0 = not accepted
//   mem2proc_data      returned load doubleword (0 when nothing returns)
//   mem2proc_tag       tag of returned load, 0 = nothing returning
//   outstanding_cnt    loads currently in flight
module mem_responder #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned NUM_TAGS  = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      proc2mem_command,
    input  logic [XLEN-1:0] proc2mem_addr,
    input  logic [63:0]     proc2mem_data,
    input  logic [1:0]      proc2mem_size,
    input  logic            mem_refuse,
    output logic [3:0]      mem2proc_response,
    output logic [63:0]     mem2proc_data,
    output logic [3:0]      mem2proc_tag,
    output logic [3:0]      outstanding_cnt
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    logic [63:0]      mem [MEM_WORDS];

    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             accept;
    logic             load_acc;
    logic             store_acc;
    logic             ret_valid;

    logic [3:0]       tag_q, tag_d;
    logic [3:0]       cnt_q, cnt_d;

    logic [3:0]       pipe_tag  [LATENCY];
    logic [63:0]      pipe_data [LATENCY];

    logic [7:0]       byte_en;
    logic [63:0]      wdata;

    // ------------------------------------------------------------------
    // Accept / grant
    // ------------------------------------------------------------------
    assign idx      = proc2mem_addr[IDX_W+2:3];
    // Doubleword index is in range iff no address bits above the index are set.
    assign in_range = (proc2mem_addr[XLEN-1:IDX_W+3] == '0);

    assign accept    = reset && !mem_refuse && in_range &&
                       ((proc2mem_command == BUS_LOAD) || (proc2mem_command == BUS_STORE));
    assign load_acc  = accept && (proc2mem_command == BUS_LOAD);
    assign store_acc = accept && (proc2mem_command == BUS_STORE);

    assign mem2proc_response = accept ? tag_q : 4'd0;

    // Tag counter cycles 1..NUM_TAGS and never produces 0.
    always_comb begin
        tag_d = tag_q;
        if (accept) begin
            tag_d = (tag_q == 4'(NUM_TAGS)) ? 4'd1 : tag_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Return pipeline and in-flight count
    // ------------------------------------------------------------------
    assign mem2proc_tag    = pipe_tag[LATENCY-1];
    assign mem2proc_data   = pipe_data[LATENCY-1];
    assign ret_valid       = (mem2proc_tag != 4'd0);
    assign outstanding_cnt = cnt_q;

    assign cnt_d = cnt_q + {3'd0, load_acc} - {3'd0, ret_valid};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_q <= 4'd1;
            cnt_q <= 4'd0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag[i]  <= 4'd0;
                pipe_data[i] <= 64'd0;
            end
        end else begin
            tag_q <= tag_d;
            cnt_q <= cnt_d;
            // Empty slots carry zero data so the outputs read 0 when idle.
            pipe_tag[0]  <= load_acc ? tag_q : 4'd0;
            pipe_data[0] <= load_acc ? mem[idx] : 64'd0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_tag[i]  <= pipe_tag[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Store byte-lane selection
    // ------------------------------------------------------------------
    // Data is replicated across the doubleword so each enabled lane just
    // picks its own byte; low address bits below the size are dropped.
    always_comb begin
        byte_en = 8'hFF;
        wdata   = proc2mem_data;
        unique case (proc2mem_size)
            SIZE_BYTE: begin
                byte_en = 8'b0000_0001 << proc2mem_addr[2:0];
                wdata   = {8{proc2mem_data[7:0]}};
            end
            SIZE_HALF: begin
                byte_en = 8'b0000_0011 << {proc2mem_addr[2:1], 1'b0};
                wdata   = {4{proc2mem_data[15:0]}};
            end
            SIZE_WORD: begin
                byte_en = 8'b0000_1111 << {proc2mem_addr[2], 2'b00};
                wdata   = {2{proc2mem_data[31:0]}};
            end
            default: begin
                byte_en = 8'hFF;
                wdata   = proc2mem_data;
            end
        endcase
    end

    // Backing store has no reset so its contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (store_acc) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus a randomized
// run, all checked against a behavioural model (byte-addressed reference memory,
// per-cycle expected return table, tag counter) kept in the bench.
module tb_mem_responder;

    localparam int LAT       = 4;
    localparam int NTAGS     = 15;
    localparam int MWORDS    = 64;
    localparam int MEM_BYTES = MWORDS * 8;
    localparam int NCYC      = 2048;

    logic        clock;
    logic        reset;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [1:0]  proc2mem_size;
    logic        mem_refuse;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [3:0]  outstanding_cnt;

    mem_responder #(
        .XLEN      (32),
        .MEM_WORDS (MWORDS),
        .LATENCY   (LAT),
        .NUM_TAGS  (NTAGS)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .proc2mem_size     (proc2mem_size),
        .mem_refuse        (mem_refuse),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag),
        .outstanding_cnt   (outstanding_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    logic [63:0] ref_mem  [MWORDS];
    int          ref_tag;
    int          epoch;
    int          cyc;
    bit          acc_load [NCYC];
    logic [3:0]  exp_tag  [NCYC];
    logic [63:0] exp_data [NCYC];
    logic [3:0]  exp_cnt  [NCYC];
    logic [3:0]  obs_tag  [NCYC];
    logic [63:0] obs_data [NCYC];
    logic [3:0]  obs_cnt  [NCYC];

    int n_checks;
    int n_pass;

    // Drive one cycle, advance the model, record observed outputs.
    task automatic step(input logic rst_val, input logic [1:0] cmd, input logic [31:0] addr,
                        input logic [63:0] data, input logic [1:0] size, input logic refuse,
                        output logic [3:0] got, output logic [3:0] want);
        logic acc;
        int   idx;
        int   nb;
        int   base;
        int   cnt;
        reset            = rst_val;
        proc2mem_command = cmd;
        proc2mem_addr    = addr;
        proc2mem_data    = data;
        proc2mem_size    = size;
        mem_refuse       = refuse;
        if (!rst_val) begin
            for (int i = cyc; i < NCYC; i++) begin
                exp_tag[i]  = 4'd0;
                exp_data[i] = 64'd0;
            end
            ref_tag = 1;
            epoch   = cyc;
        end
        acc  = rst_val && !refuse && (cmd == 2'd1 || cmd == 2'd2) && (addr < MEM_BYTES);
        want = acc ? 4'(ref_tag) : 4'd0;
        idx  = int'(addr >> 3);
        if (acc && cmd == 2'd1) begin
            exp_tag[cyc+LAT]  = 4'(ref_tag);
            exp_data[cyc+LAT] = ref_mem[idx];
            acc_load[cyc]     = 1'b1;
        end
        if (acc && cmd == 2'd2) begin
            nb   = 1 << int'(size);
            base = (int'(addr[2:0]) / nb) * nb;
            for (int k = 0; k < nb; k++) ref_mem[idx][8*(base+k) +: 8] = data[8*k +: 8];
        end
        if (acc) ref_tag = (ref_tag == NTAGS) ? 1 : ref_tag + 1;
        cnt = 0;
        if (rst_val) begin
            for (int i = cyc - LAT; i < cyc; i++) begin
                if (i >= 0 && i >= epoch && acc_load[i]) cnt++;
            end
        end
        exp_cnt[cyc] = 4'(cnt);
        @(negedge clock);
        got           = mem2proc_response;
        obs_tag[cyc]  = mem2proc_tag;
        obs_data[cyc] = mem2proc_data;
        obs_cnt[cyc]  = outstanding_cnt;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic [3:0] g, w;
        for (int i = 0; i < n; i++) step(1'b1, 2'd0, 32'd0, 64'd0, 2'd0, 1'b0, g, w);
    endtask

    task automatic test_reset();
        logic [3:0] g, w;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd1, 32'h10, 64'd0, 2'd3, 1'b0, g, w);
            n_checks++;
            if (g !== 4'd0 || obs_tag[cyc-1] !== 4'd0 || obs_data[cyc-1] !== 64'd0 ||
                obs_cnt[cyc-1] !== 4'd0)
                $display("FAIL reset_state: resp %0d tag %0d data %h cnt %0d, want all 0",
                         g, obs_tag[cyc-1], obs_data[cyc-1], obs_cnt[cyc-1]);
            else n_pass++;
        end
        idle(1);
    endtask

    task automatic test_store_load();
        logic [3:0] g, w;
        int s, ld;
        s = cyc;
        step(1'b1, 2'd2, 32'h10, 64'h1122334455667788, 2'd3, 1'b0, g, w);
        n_checks++;
        if (g !== 4'd1) $display("FAIL first_store_resp: got %0d want 1", g); else n_pass++;
        ld = cyc;
        step(1'b1, 2'd1, 32'h10, 64'd0, 2'd3, 1'b0, g, w);
        n_checks++;
        if (g !== 4'd2) $display("FAIL first_load_resp: got %0d want 2", g); else n_pass++;
        idle(LAT + 2);
        n_checks++;
        if (obs_tag[ld+LAT] !== 4'd2 || obs_data[ld+LAT] !== 64'h1122334455667788)
            $display("FAIL first_load_ret: got tag %0d data %h want tag 2 data 1122334455667788",
                     obs_tag[ld+LAT], obs_data[ld+LAT]);
        else n_pass++;
        for (int c = s; c < cyc; c++) begin
            n_checks++;
            if (obs_tag[c] !== exp_tag[c] || obs_data[c] !== exp_data[c])
                $display("FAIL store_load_ret cyc %0d: got tag %0d data %h want tag %0d data %h",
                         c, obs_tag[c], obs_data[c], exp_tag[c], exp_data[c]);
            else n_pass++;
        end
    endtask

    task automatic test_init_mem();
        logic [3:0] g, w;
        for (int i = 0; i < MWORDS; i++) begin
            step(1'b1, 2'd2, 32'(i * 8), {$urandom, $urandom}, 2'd3, 1'b0, g, w);
            n_checks++;
            if (g !== w) $display("FAIL init_store_resp: got %0d want %0d", g, w); else n_pass++;
        end
    endtask

    task automatic test_byte_lanes();
        logic [3:0] g, w;
        int s, l1, l2;
        s = cyc;
        step(1'b1, 2'd2, 32'h10, 64'd0, 2'd3, 1'b0, g, w);
        step(1'b1, 2'd2, 32'h13, 64'hFFFF_FFFF_FFFF_FFAB, 2'd0, 1'b0, g, w);
        l1 = cyc;
        step(1'b1, 2'd1, 32'h10, 64'd0, 2'd3, 1'b0, g, w);
        step(1'b1, 2'd2, 32'h14, 64'h1234_5678_DEAD_BEEF, 2'd2, 1'b0, g, w);
        l2 = cyc;
        step(1'b1, 2'd1, 32'h10, 64'd0, 2'd3, 1'b0, g, w);
        idle(LAT + 2);
        n_checks++;
        if (obs_data[l1+LAT] !== 64'h00000000AB000000)
            $display("FAIL byte_store: got %h want 00000000ab000000", obs_data[l1+LAT]);
        else n_pass++;
        n_checks++;
        if (obs_data[l2+LAT] !== 64'hDEADBEEFAB000000)
            $display("FAIL word_store: got %h want deadbeefab000000", obs_data[l2+LAT]);
        else n_pass++;
        for (int c = s; c < cyc; c++) begin
            n_checks++;
            if (obs_tag[c] !== exp_tag[c] || obs_data[c] !== exp_data[c] ||
                obs_cnt[c] !== exp_cnt[c])
                $display("FAIL lanes_ret cyc %0d: got tag %0d data %h cnt %0d want %0d %h %0d",
                         c, obs_tag[c], obs_data[c], obs_cnt[c], exp_tag[c], exp_data[c],
                         exp_cnt[c]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] g, w;
        logic [3:0] want_resp [6];
        int s, l0, peak;
        want_resp = '{4'd14, 4'd15, 4'd1, 4'd2, 4'd3, 4'd4};
        while (ref_tag != 14)
            step(1'b1, 2'd2, 32'($urandom_range(0, MEM_BYTES - 1)), {$urandom, $urandom},
                 2'($urandom_range(0, 3)), 1'b0, g, w);
        s  = cyc;
        l0 = cyc;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 2'd1, 32'($urandom_range(0, MEM_BYTES - 1)), 64'd0, 2'd3, 1'b0, g, w);
            n_checks++;
            if (g !== want_resp[i])
                $display("FAIL b2b_resp %0d: got %0d want %0d", i, g, want_resp[i]);
            else n_pass++;
        end
        idle(LAT + 2);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs_tag[l0+i+LAT] !== want_resp[i] || obs_data[l0+i+LAT] !== exp_data[l0+i+LAT])
                $display("FAIL b2b_ret %0d: got tag %0d data %h want tag %0d data %h", i,
                         obs_tag[l0+i+LAT], obs_data[l0+i+LAT], want_resp[i], exp_data[l0+i+LAT]);
            else n_pass++;
        end
        peak = 0;
        for (int c = s; c < cyc; c++) begin
            if (int'(obs_cnt[c]) > peak) peak = int'(obs_cnt[c]);
            n_checks++;
            if (obs_cnt[c] !== exp_cnt[c] || obs_tag[c] !== exp_tag[c])
                $display("FAIL b2b_cyc %0d: got cnt %0d tag %0d want cnt %0d tag %0d", c,
                         obs_cnt[c], obs_tag[c], exp_cnt[c], exp_tag[c]);
            else n_pass++;
        end
        n_checks++;
        if (peak != LAT) $display("FAIL b2b_peak_cnt: got %0d want %0d", peak, LAT);
        else n_pass++;
    endtask

    task automatic test_rejects();
        logic [3:0] g, w;
        logic [3:0] saved;
        int s;
        s     = cyc;
        saved = 4'(ref_tag);
        step(1'b1, 2'd1, 32'h200, 64'd0, 2'd3, 1'b0, g, w);
        n_checks++;
        if (g !== 4'd0) $display("FAIL reject_range: got %0d want 0", g); else n_pass++;
        step(1'b1, 2'd1, 32'h10, 64'd0, 2'd3, 1'b1, g, w);
        n_checks++;
        if (g !== 4'd0) $display("FAIL reject_refuse: got %0d want 0", g); else n_pass++;
        step(1'b1, 2'd3, 32'h10, 64'd0, 2'd3, 1'b0, g, w);
        n_checks++;
        if (g !== 4'd0) $display("FAIL reject_illegal: got %0d want 0", g); else n_pass++;
        step(1'b1, 2'd0, 32'h10, 64'd0, 2'd3, 1'b0, g, w);
        n_checks++;
        if (g !== 4'd0) $display("FAIL reject_none: got %0d want 0", g); else n_pass++;
        step(1'b1, 2'd1, 32'h8, 64'd0, 2'd3, 1'b0, g, w);
        n_checks++;
        if (g !== saved) $display("FAIL reject_tag_kept: got %0d want %0d", g, saved);
        else n_pass++;
        idle(LAT + 2);
        for (int c = s; c < cyc; c++) begin
            n_checks++;
            if (obs_tag[c] !== exp_tag[c] || obs_data[c] !== exp_data[c])
                $display("FAIL reject_ret cyc %0d: got tag %0d data %h want tag %0d data %h",
                         c, obs_tag[c], obs_data[c], exp_tag[c], exp_data[c]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [3:0]  g, w;
        logic [31:0] a;
        int s;
        s = cyc;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(MEM_BYTES, 4095))
                                            : 32'($urandom_range(0, MEM_BYTES - 1));
            step(1'b1, 2'($urandom_range(0, 3)), a, {$urandom, $urandom},
                 2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), g, w);
            n_checks++;
            if (g !== w) $display("FAIL rand_resp cyc %0d: got %0d want %0d", cyc - 1, g, w);
            else n_pass++;
        end
        idle(LAT + 2);
        for (int c = s; c < cyc; c++) begin
            n_checks++;
            if (obs_tag[c] !== exp_tag[c] || obs_data[c] !== exp_data[c] ||
                obs_cnt[c] !== exp_cnt[c])
                $display("FAIL rand_ret cyc %0d: got %0d %h %0d want %0d %h %0d", c,
                         obs_tag[c], obs_data[c], obs_cnt[c], exp_tag[c], exp_data[c],
                         exp_cnt[c]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] g, w;
        int s, r, ld;
        s = cyc;
        for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 32'(32'h20 + 8 * i), 64'd0, 2'd3, 1'b0, g, w);
        idle(1);
        r = cyc;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 2'd1, 32'h20, 64'd0, 2'd3, 1'b0, g, w);
            n_checks++;
            if (g !== 4'd0) $display("FAIL midreset_resp: got %0d want 0", g); else n_pass++;
        end
        idle(LAT + 2);
        for (int c = r; c < cyc; c++) begin
            n_checks++;
            if (obs_tag[c] !== 4'd0 || obs_cnt[c] !== 4'd0)
                $display("FAIL midreset_quiet cyc %0d: got tag %0d cnt %0d want 0 0", c,
                         obs_tag[c], obs_cnt[c]);
            else n_pass++;
        end
        ld = cyc;
        step(1'b1, 2'd1, 32'h28, 64'd0, 2'd3, 1'b0, g, w);
        n_checks++;
        if (g !== 4'd1) $display("FAIL midreset_first_tag: got %0d want 1", g); else n_pass++;
        idle(LAT + 2);
        n_checks++;
        if (obs_tag[ld+LAT] !== 4'd1 || obs_data[ld+LAT] !== ref_mem[5])
            $display("FAIL midreset_mem_kept: got tag %0d data %h want tag 1 data %h",
                     obs_tag[ld+LAT], obs_data[ld+LAT], ref_mem[5]);
        else n_pass++;
        for (int c = s; c < cyc; c++) begin
            n_checks++;
            if (obs_tag[c] !== exp_tag[c] || obs_data[c] !== exp_data[c] ||
                obs_cnt[c] !== exp_cnt[c])
                $display("FAIL midreset_ret cyc %0d: got %0d %h %0d want %0d %h %0d", c,
                         obs_tag[c], obs_data[c], obs_cnt[c], exp_tag[c], exp_data[c],
                         exp_cnt[c]);
            else n_pass++;
        end
    endtask

    task automatic test_load_then_store();
        logic [3:0]  g, w;
        logic [63:0] old_v, new_v;
        int l1, l2;
        old_v = ref_mem[4];
        new_v = {$urandom, $urandom};
        l1 = cyc;
        step(1'b1, 2'd1, 32'h20, 64'd0, 2'd3, 1'b0, g, w);
        step(1'b1, 2'd2, 32'h20, new_v, 2'd3, 1'b0, g, w);
        l2 = cyc;
        step(1'b1, 2'd1, 32'h20, 64'd0, 2'd3, 1'b0, g, w);
        idle(LAT + 2);
        n_checks++;
        if (obs_data[l1+LAT] !== old_v)
            $display("FAIL load_before_store: got %h want %h", obs_data[l1+LAT], old_v);
        else n_pass++;
        n_checks++;
        if (obs_data[l2+LAT] !== new_v)
            $display("FAIL load_after_store: got %h want %h", obs_data[l2+LAT], new_v);
        else n_pass++;
        n_checks++;
        if (obs_tag[l2+LAT] !== exp_tag[l2+LAT])
            $display("FAIL load_after_store_tag: got %0d want %0d", obs_tag[l2+LAT],
                     exp_tag[l2+LAT]);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        epoch    = 0;
        ref_tag  = 1;
        for (int i = 0; i < NCYC; i++) begin
            acc_load[i] = 1'b0;
            exp_tag[i]  = 4'd0;
            exp_data[i] = 64'd0;
            exp_cnt[i]  = 4'd0;
        end
        reset            = 1'b0;
        proc2mem_command = 2'd0;
        proc2mem_addr    = 32'd0;
        proc2mem_data    = 64'd0;
        proc2mem_size    = 2'd0;
        mem_refuse       = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_store_load();
        test_init_mem();
        test_byte_lanes();
        test_back_to_back();
        test_rejects();
        test_random();
        test_reset_mid();
        test_load_then_store();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor memory bus: accepts BUS_LOAD/BUS_STORE commands, grants a nonzero tag on the same cycle, and returns load data tagged a fixed number of cycles later.
- Holds a synthesizable 64-bit-wide backing store.
- Sits opposite the pipeline top in testbench and FPGA builds, replacing the behavioural memory model.

Parameters:
- MEM_WORDS, 64, number of 64-bit doublewords in the backing store (power of 2).
- LATENCY, 4, cycles from accept to tagged data return (1..15).
- NUM_TAGS, 15, tag values in use: 1..NUM_TAGS, with NUM_TAGS >= LATENCY and NUM_TAGS <= 15.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- proc2mem_command  in  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2, 3=illegal.
- proc2mem_addr  in  XLEN  byte address.
- proc2mem_data  in  64  store data, right-aligned for sub-doubleword sizes.
- proc2mem_size  in  2  BYTE=0, HALF=1, WORD=2, DOUBLE=3.
- mem_refuse  in  1  test hook; forces rejection this cycle.
- mem2proc_response  out  4  granted tag this cycle, 0 = not accepted.
- mem2proc_data  out  64  returned load doubleword.
- mem2proc_tag  out  4  tag of returned load, 0 = nothing returning.
- outstanding_cnt  out  4  loads in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - return pipeline slots invalid; mem2proc_tag=0; mem2proc_data=0; outstanding_cnt=0; tag counter=1.
  - mem2proc_response=0 combinationally while reset is held.
  - Backing store contents are not cleared.
- Accept conditions (combinational, same cycle): a command is accepted iff all of:
  - reset=1;
  - mem_refuse=0;
  - command is LOAD or STORE;
  - addr[XLEN-1:3] < MEM_WORDS.
- Grant:
  - accepted: mem2proc_response = current tag counter;
  - otherwise: response = 0, with no state change.
  - Illegal command 3 and BUS_NONE are always rejected.
- Tag counter: advances on every accepted command (load or store), 1→2→…→NUM_TAGS→1. It never yields 0.
- Load, accepted in cycle 0:
  - doubleword mem[addr[log2(MEM_WORDS)+2:3]] is sampled at the end of cycle 0;
  - data and tag travel through a LATENCY-deep shift pipeline;
  - mem2proc_tag and mem2proc_data equal the granted tag and sampled data during cycle LATENCY (registered outputs), for exactly one cycle;
  - in every other cycle both outputs are 0.
  - Returned data is always the full aligned doubleword regardless of size; addr[2:0] is ignored.
- Store, accepted in cycle 0:
  - the write takes effect at the end of cycle 0, with byte lanes selected by size and addr[2:0]:
    - BYTE: lane addr[2:0] ← data[7:0].
    - HALF: lanes {addr[2:1],0}..+1 ← data[15:0].
    - WORD: lanes {addr[2],00}..+3 ← data[31:0].
    - DOUBLE: all lanes ← data.
  - Misaligned low address bits below the size granularity are ignored.
  - Stores consume a tag but never produce a tag return.
- Ordering:
  - one command per cycle, so same-cycle load/store conflicts are impossible;
  - a load accepted in a later cycle than a store to the same doubleword sees the stored value;
  - a load's data is fixed at acceptance, so later stores do not alter it.
- Tag uniqueness: at most LATENCY loads are in flight and NUM_TAGS >= LATENCY, so no tag is reused while still outstanding.
- outstanding_cnt: +1 on load accept, -1 on the cycle the return is presented; both in the same cycle leaves it unchanged. Maximum value is LATENCY.
- Back-to-back loads every cycle return on consecutive cycles in order with consecutive tags.
- Reset mid-operation: all in-flight loads are discarded and their tags are never returned. The first accept after reset is granted tag 1.

Test Plan:
- Reset, then STORE DOUBLE addr 0x10 data 0x1122334455667788; next cycle LOAD addr 0x10 → store response=1, load response=2; in the fourth cycle after the load request, tag=2 and data=0x1122334455667788; in all other cycles tag=0 and data=0.
- STORE BYTE addr 0x13 data 0xAB over a doubleword of 0 at 0x10, then LOAD 0x10 → data=0x00000000AB000000. Follow with STORE WORD addr 0x14 data 0xDEADBEEF, then LOAD → data=0xDEADBEEFAB000000.
- 6 consecutive LOADs, one per cycle, starting from tag 14 → responses 14, 15, 1, 2, 3, 4; returns on 6 consecutive cycles in the same order; outstanding_cnt peaks at 4.
- LOAD with addr=0x200 (doubleword index 64, out of range), LOAD with mem_refuse=1, and command=3 → response=0 in each case; no tag return; tag counter unchanged.
- Issue 3 LOADs, then pull reset low 2 cycles after the last accept → mem2proc_tag stays 0 thereafter; outstanding_cnt=0; first LOAD after release gets response=1; store contents survive the reset.
- LOAD addr 0x20, then STORE DOUBLE addr 0x20 new value in the next cycle → the load returns the old value; a subsequent LOAD returns the new value.
